// File: rtl/serial_64_cla_4_adder.sv
// serial_64_cla_4_adder
// 64-bit adder with carry-in and carry-out, followed by one register stage.
// The adder is split into four 16-bit segments. The segment carries ripple
// from segment 0 (LSB) to segment 3 (MSB). Each segment has four 4-bit CLA
// groups. A Brent-Kung prefix over the group (G,P) pairs gives the carry into
// each group.
// The prefix tree is written out for exactly four groups per segment, so
// SEG_W must equal 4*GRP_W.
module serial_64_cla_4_adder #(
  parameter int WIDTH = 64,
  parameter int SEG_W = 16,
  parameter int GRP_W = 4,
  parameter int NSEG  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NGRP = SEG_W / GRP_W;

  // Carry into every bit of a group, from the group carry-in.
  // Each carry is a flat sum of products, so carries do not ripple
  // bit to bit inside the group.
  function automatic logic [GRP_W-1:0] grp_carries(input logic [GRP_W-1:0] g,
                                                   input logic [GRP_W-1:0] p,
                                                   input logic             ci);
    logic [GRP_W-1:0] c;
    logic             t;
    for (int j = 0; j < GRP_W; j++) begin
      t = ci;
      for (int m = 0; m < j; m++) t = t & p[m];
      c[j] = t;
      for (int k = 0; k < j; k++) begin
        t = g[k];
        for (int m = k + 1; m < j; m++) t = t & p[m];
        c[j] = c[j] | t;
      end
    end
    return c;
  endfunction

  // Group generate: g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0 (for GRP_W = 4).
  function automatic logic grp_gen(input logic [GRP_W-1:0] g,
                                   input logic [GRP_W-1:0] p);
    logic gg;
    logic t;
    gg = 1'b0;
    for (int k = 0; k < GRP_W; k++) begin
      t = g[k];
      for (int m = k + 1; m < GRP_W; m++) t = t & p[m];
      gg = gg | t;
    end
    return gg;
  endfunction

  logic [NSEG:0]    w_seg_c;
  logic [WIDTH-1:0] w_sum;

  assign w_seg_c[0] = cin;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
      logic [NGRP-1:0] w_grp_g;
      logic [NGRP-1:0] w_grp_p;
      logic [NGRP-1:0] w_grp_cin;
      logic            w_g10, w_p10, w_g32, w_p32, w_g30, w_p30;

      for (gj = 0; gj < NGRP; gj++) begin : g_grp
        localparam int BASE = gi * SEG_W + gj * GRP_W;
        logic [GRP_W-1:0] w_g;
        logic [GRP_W-1:0] w_p;
        logic [GRP_W-1:0] w_c;

        assign w_g          = x1[BASE +: GRP_W] & x2[BASE +: GRP_W];
        assign w_p          = x1[BASE +: GRP_W] ^ x2[BASE +: GRP_W];
        assign w_grp_g[gj]  = grp_gen(w_g, w_p);
        assign w_grp_p[gj]  = &w_p;
        assign w_c          = grp_carries(w_g, w_p, w_grp_cin[gj]);
        assign w_sum[BASE +: GRP_W] = w_p ^ w_c;
      end

      // Up-sweep: pairs (1:0), (3:2), then the whole segment (3:0).
      assign w_g10 = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0]);
      assign w_p10 = w_grp_p[1] & w_grp_p[0];
      assign w_g32 = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2]);
      assign w_p32 = w_grp_p[3] & w_grp_p[2];
      assign w_g30 = w_g32 | (w_p32 & w_g10);
      assign w_p30 = w_p32 & w_p10;

      // Down-sweep: carry into each group from the segment carry-in.
      assign w_grp_cin[0] = w_seg_c[gi];
      assign w_grp_cin[1] = w_grp_g[0] | (w_grp_p[0] & w_seg_c[gi]);
      assign w_grp_cin[2] = w_g10 | (w_p10 & w_seg_c[gi]);
      assign w_grp_cin[3] = w_grp_g[2] | (w_grp_p[2] & w_grp_cin[2]);

      // Segment carry-out feeds the next segment.
      assign w_seg_c[gi+1] = w_g30 | (w_p30 & w_seg_c[gi]);
    end
  endgenerate

  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  // Output register: captures the sum and the final carry every cycle.
  // Reset clears both outputs at once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_seg_c[NSEG];
    end
  end

  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_64_cla_4_adder.sv
// Testbench for serial_64_cla_4_adder.
// Directed vectors with hand-computed results are applied back-to-back, one
// per cycle. The bench then checks asynchronous reset in the middle of a run
// and adds a short random run checked against a 65-bit "+" model.
module tb_serial_64_cla_4_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] x1  = '0;
  logic [63:0] x2  = '0;
  logic        cin = 1'b0;
  logic [63:0] s;
  logic        cout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic [64:0] exp;  // {cout, s}
  } vec_t;

  vec_t vecs[$];

  serial_64_cla_4_adder dut (
    .clk  (clk),
    .rst  (rst),
    .x1   (x1),
    .x2   (x2),
    .cin  (cin),
    .s    (s),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got cout=%0b s=%h, expected cout=%0b s=%h",
               tag, got[64], got[63:0], exp[64], exp[63:0]);
    end
  endtask

  // Drive on the falling edge, then sample just after the next rising edge.
  task automatic apply(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input logic [64:0] exp);
    @(negedge clk);
    x1  = a;
    x2  = b;
    cin = ci;
    @(posedge clk);
    #1;
    check_val(tag, {cout, s}, exp);
    $display("[TB] %-12s x1=%h x2=%h cin=%0b -> cout=%0b s=%h", tag, a, b, ci, cout, s);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] rexp;

    vecs.push_back('{tag:"regress999", a:64'd999, b:64'hFFFF_FFFF_FFFF_FFFF, ci:1'b1, exp:{1'b1, 64'd999}});
    vecs.push_back('{tag:"full_chain", a:64'hFFFF_FFFF_FFFF_FFFF, b:64'd0, ci:1'b1, exp:{1'b1, 64'd0}});
    vecs.push_back('{tag:"seg_bound", a:64'h0000_0000_0000_FFFF, b:64'd1, ci:1'b0, exp:{1'b0, 64'h0000_0000_0001_0000}});
    vecs.push_back('{tag:"zero", a:64'd0, b:64'd0, ci:1'b0, exp:{1'b0, 64'd0}});
    vecs.push_back('{tag:"msb_pair", a:64'h8000_0000_0000_0000, b:64'h8000_0000_0000_0000, ci:1'b1, exp:{1'b1, 64'd1}});
    vecs.push_back('{tag:"mixed", a:64'h1234_5678_9ABC_DEF0, b:64'h1111_1111_1111_1111, ci:1'b0, exp:{1'b0, 64'h2345_6789_ABCD_F001}});
    vecs.push_back('{tag:"seg0_seg1", a:64'h0000_FFFF_0000_FFFF, b:64'd1, ci:1'b1, exp:{1'b0, 64'h0000_FFFF_0001_0001}});
    vecs.push_back('{tag:"seg2_seg3", a:64'hFFFF_FFFF_0000_0000, b:64'h0000_0001_0000_0000, ci:1'b0, exp:{1'b1, 64'd0}});
    vecs.push_back('{tag:"signed_wrap", a:64'h7FFF_FFFF_FFFF_FFFF, b:64'd1, ci:1'b0, exp:{1'b0, 64'h8000_0000_0000_0000}});
    vecs.push_back('{tag:"all_prop_c1", a:64'hAAAA_AAAA_AAAA_AAAA, b:64'h5555_5555_5555_5555, ci:1'b1, exp:{1'b1, 64'd0}});
    vecs.push_back('{tag:"all_prop_c0", a:64'hAAAA_AAAA_AAAA_AAAA, b:64'h5555_5555_5555_5555, ci:1'b0, exp:{1'b0, 64'hFFFF_FFFF_FFFF_FFFF}});
    vecs.push_back('{tag:"grp0_grp1", a:64'h0000_0000_0000_000F, b:64'd1, ci:1'b0, exp:{1'b0, 64'h0000_0000_0000_0010}});
    vecs.push_back('{tag:"grp2_grp3", a:64'h0000_0000_0000_0FFF, b:64'd1, ci:1'b0, exp:{1'b0, 64'h0000_0000_0000_1000}});
    vecs.push_back('{tag:"max_max_c1", a:64'hFFFF_FFFF_FFFF_FFFF, b:64'hFFFF_FFFF_FFFF_FFFF, ci:1'b1, exp:{1'b1, 64'hFFFF_FFFF_FFFF_FFFF}});

    // Reset from the start: outputs cleared without any clock edge
    #1 rst = 1'b1;
    #1 check_val("reset_init", {cout, s}, 65'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, back-to-back (new inputs every cycle)
    foreach (vecs[i]) apply(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].exp);

    // Mid-run reset: outputs are nonzero, then rst clears them between edges
    apply("pre_reset", 64'h0000_0000_0000_1234, 64'h0000_0000_0000_0001, 1'b0,
          {1'b0, 64'h0000_0000_0000_1235});
    #1 rst = 1'b1;
    #1 check_val("reset_async", {cout, s}, 65'd0);
    // Inputs that change while reset is held must not reach the outputs
    @(negedge clk);
    x1  = 64'hFFFF_FFFF_FFFF_FFFF;
    x2  = 64'hFFFF_FFFF_FFFF_FFFF;
    cin = 1'b1;
    @(posedge clk);
    #1 check_val("reset_hold", {cout, s}, 65'd0);
    // Release reset; the next edge loads the current inputs
    @(negedge clk);
    rst = 1'b0;
    x1  = 64'd5;
    x2  = 64'd7;
    cin = 1'b1;
    @(posedge clk);
    #1 check_val("reset_release", {cout, s}, {1'b0, 64'd13});
    $display("[TB] reset_release x1=%h x2=%h cin=%0b -> cout=%0b s=%h", x1, x2, cin, cout, s);

    // Back-to-back random inputs checked against a 65-bit "+" model
    for (int k = 0; k < 2000; k++) begin
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rc   = 1'($urandom_range(0, 1));
      rexp = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
      apply("random", ra, rb, rc, rexp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
